// File: rtl/i8080_frame_ctrl.sv
// i8080 host write-bus decoder: MIPI-DBI command subset, RAMWR pixel streaming into the
// display FIFO and frame-end signalling. Optional dropped-byte counter via FIFO_OVF_CNT_EN.
module i8080_frame_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned H_RES       = 800,
    parameter int unsigned V_RES       = 480
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       i8080_CS,
    input  logic       i8080_RS,
    input  logic       i8080_WR,
    input  logic [7:0] i8080_D,
    input  logic       FIFO_Full,
    output logic       FIFOWe,
    output logic [7:0] RGBData,
    output logic       FrameCtrl,
    output logic       LCD_BL,
    output logic       Busy,
    output logic       Overflow,
    output logic [7:0] OvfCnt
);

    localparam logic [ADDR_W-1:0] EC_RST = ADDR_W'(H_RES - 1);
    localparam logic [ADDR_W-1:0] EP_RST = ADDR_W'(V_RES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_CASET, ST_PASET, ST_RAMWR} state_t;

    state_t                      state;
    logic [SYNC_STAGES-1:0]      cs_sync, rs_sync, wr_sync;
    logic [SYNC_STAGES-1:0][7:0] d_sync;
    logic                        wr_q;
    logic [ADDR_W-1:0]           sc, ec, sp, ep, col, row;
    logic                        phase;
    logic [1:0]                  pcnt;
    logic [2:0][7:0]             prm;

    logic                        byte_ev_c, is_cmd_c, swreset_c;
    logic [7:0]                  byte_d_c;
    logic [ADDR_W-1:0]           p_start_c, p_end_c, p_end_cl_c;

    // Synchronizers idle high so reset release never looks like a selected WR rise
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cs_sync <= '1;
            rs_sync <= '1;
            wr_sync <= '1;
            d_sync  <= '0;
            wr_q    <= 1'b1;
        end else begin
            cs_sync <= {cs_sync[SYNC_STAGES-2:0], i8080_CS};
            rs_sync <= {rs_sync[SYNC_STAGES-2:0], i8080_RS};
            wr_sync <= {wr_sync[SYNC_STAGES-2:0], i8080_WR};
            d_sync  <= {d_sync[SYNC_STAGES-2:0], i8080_D};
            wr_q    <= wr_sync[SYNC_STAGES-1];
        end
    end

    always_comb begin
        byte_ev_c  = wr_sync[SYNC_STAGES-1] & ~wr_q & ~cs_sync[SYNC_STAGES-1];
        is_cmd_c   = ~rs_sync[SYNC_STAGES-1];
        byte_d_c   = d_sync[SYNC_STAGES-1];
        swreset_c  = byte_ev_c & is_cmd_c & (byte_d_c == 8'h01);
        p_start_c  = ADDR_W'({prm[0], prm[1]});
        p_end_c    = ADDR_W'({prm[2], byte_d_c});
        p_end_cl_c = (p_end_c < p_start_c) ? p_start_c : p_end_c;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= ST_IDLE;
            sc        <= '0;
            ec        <= EC_RST;
            sp        <= '0;
            ep        <= EP_RST;
            col       <= '0;
            row       <= '0;
            phase     <= 1'b0;
            pcnt      <= '0;
            prm       <= '0;
            FIFOWe    <= 1'b0;
            RGBData   <= '0;
            FrameCtrl <= 1'b0;
            LCD_BL    <= 1'b0;
            Busy      <= 1'b0;
            Overflow  <= 1'b0;
        end else begin
            FIFOWe    <= 1'b0;
            FrameCtrl <= 1'b0;
            if (swreset_c) begin
                state    <= ST_IDLE;
                sc       <= '0;
                ec       <= EC_RST;
                sp       <= '0;
                ep       <= EP_RST;
                col      <= '0;
                row      <= '0;
                phase    <= 1'b0;
                pcnt     <= '0;
                prm      <= '0;
                RGBData  <= '0;
                LCD_BL   <= 1'b0;
                Busy     <= 1'b0;
                Overflow <= 1'b0;
            end else if (byte_ev_c && is_cmd_c) begin
                pcnt  <= '0;
                col   <= sc;
                row   <= sp;
                phase <= 1'b0;
                Busy  <= (byte_d_c == 8'h2C);
                case (byte_d_c)
                    8'h2A:   state <= ST_CASET;
                    8'h2B:   state <= ST_PASET;
                    8'h2C:   state <= ST_RAMWR;
                    8'h29: begin
                        state  <= ST_IDLE;
                        LCD_BL <= 1'b1;
                    end
                    8'h28: begin
                        state  <= ST_IDLE;
                        LCD_BL <= 1'b0;
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (byte_ev_c) begin
                case (state)
                    ST_CASET, ST_PASET: begin
                        if (pcnt == 2'd3) begin
                            if (state == ST_CASET) begin
                                sc <= p_start_c;
                                ec <= p_end_cl_c;
                            end else begin
                                sp <= p_start_c;
                                ep <= p_end_cl_c;
                            end
                            pcnt  <= '0;
                            state <= ST_IDLE;
                        end else begin
                            prm[pcnt] <= byte_d_c;
                            pcnt      <= pcnt + 2'd1;
                        end
                    end
                    ST_RAMWR: begin
                        if (FIFO_Full) begin
                            Overflow <= 1'b1;
                        end else begin
                            FIFOWe  <= 1'b1;
                            RGBData <= byte_d_c;
                        end
                        phase <= ~phase;
                        // Two bytes per pixel: position advances after the LO byte
                        if (phase) begin
                            if (col == ec) begin
                                col <= sc;
                                if (row == ep) begin
                                    FrameCtrl <= 1'b1;
                                    Busy      <= 1'b0;
                                    state     <= ST_IDLE;
                                end else begin
                                    row <= row + ADDR_W'(1);
                                end
                            end else begin
                                col <= col + ADDR_W'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef FIFO_OVF_CNT_EN
    logic [7:0] ovf_cnt;
    logic       drop_c;

    assign drop_c = byte_ev_c & ~is_cmd_c & (state == ST_RAMWR) & FIFO_Full;

    // Saturating count of pixel bytes lost to a full FIFO
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ovf_cnt <= '0;
        end else if (swreset_c) begin
            ovf_cnt <= '0;
        end else if (drop_c && (ovf_cnt != 8'hFF)) begin
            ovf_cnt <= ovf_cnt + 8'd1;
        end
    end

    assign OvfCnt = ovf_cnt;
`else
    assign OvfCnt = 8'h00;
`endif

endmodule

// File: tb/tb_i8080_frame_ctrl.sv
// Randomized bench for i8080_frame_ctrl against a byte-level behavioural model.
module tb_i8080_frame_ctrl;
    localparam int S      = 2;
    localparam int ADDR_W = 10;
    localparam int H_RES  = 800;
    localparam int V_RES  = 480;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       i8080_CS, i8080_RS, i8080_WR;
    logic [7:0] i8080_D;
    logic       FIFO_Full;
    logic       FIFOWe, FrameCtrl, LCD_BL, Busy, Overflow;
    logic [7:0] RGBData, OvfCnt;

    always #5 CLK = ~CLK;

    i8080_frame_ctrl #(.SYNC_STAGES(S), .ADDR_W(ADDR_W), .H_RES(H_RES), .V_RES(V_RES)) dut (
        .CLK(CLK), .nRST(nRST), .i8080_CS(i8080_CS), .i8080_RS(i8080_RS),
        .i8080_WR(i8080_WR), .i8080_D(i8080_D), .FIFO_Full(FIFO_Full),
        .FIFOWe(FIFOWe), .RGBData(RGBData), .FrameCtrl(FrameCtrl), .LCD_BL(LCD_BL),
        .Busy(Busy), .Overflow(Overflow), .OvfCnt(OvfCnt)
    );

    int vectors = 0;
    int miscompares = 0;
    int we_seen = 0;
    int fr_seen = 0;

    typedef struct {
        bit         we;
        logic [7:0] data;
        bit         frame;
    } ev_t;
    ev_t exp_q[$];
    ev_t cmp_e;

    // Model: mode 0 idle, 1 caset, 2 paset, 3 ramwr; frame tracked as byte count
    int         m_mode, m_pcnt, m_sc, m_ec, m_sp, m_ep, m_nbytes, m_ovfcnt;
    bit         m_bl, m_ovf;
    logic [7:0] m_prm[3];

    function automatic void m_reset();
        m_mode = 0; m_pcnt = 0; m_nbytes = 0;
        m_sc = 0; m_ec = H_RES - 1; m_sp = 0; m_ep = V_RES - 1;
        m_bl = 0; m_ovf = 0; m_ovfcnt = 0;
    endfunction

    function automatic void model_byte(input bit rs, input logic [7:0] d, input bit full);
        int s, e, total;
        bit fr;
        ev_t ev;
        if (!rs) begin
            m_pcnt = 0; m_nbytes = 0;
            case (d)
                8'h2A: m_mode = 1;
                8'h2B: m_mode = 2;
                8'h2C: m_mode = 3;
                8'h29: begin m_mode = 0; m_bl = 1; end
                8'h28: begin m_mode = 0; m_bl = 0; end
                8'h01: m_reset();
                default: m_mode = 0;
            endcase
        end else if (m_mode == 1 || m_mode == 2) begin
            if (m_pcnt < 3) begin
                m_prm[m_pcnt] = d;
                m_pcnt++;
            end else begin
                s = ((int'(m_prm[0]) << 8) | int'(m_prm[1])) % (1 << ADDR_W);
                e = ((int'(m_prm[2]) << 8) | int'(d)) % (1 << ADDR_W);
                if (e < s) e = s;
                if (m_mode == 1) begin m_sc = s; m_ec = e; end
                else begin m_sp = s; m_ep = e; end
                m_mode = 0; m_pcnt = 0;
            end
        end else if (m_mode == 3) begin
            m_nbytes++;
            total = (m_ec - m_sc + 1) * (m_ep - m_sp + 1) * 2;
            fr = (m_nbytes == total);
            if (!full || fr) begin
                ev.we = !full; ev.data = d; ev.frame = fr;
                exp_q.push_back(ev);
            end
            if (full) begin
                m_ovf = 1;
                if (m_ovfcnt < 255) m_ovfcnt++;
            end
            if (fr) m_mode = 0;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Pixel stream compare against the model's expected write/frame events
    always @(negedge CLK) begin
        if (nRST === 1'b1 && (FIFOWe === 1'b1 || FrameCtrl === 1'b1)) begin
            we_seen += int'(FIFOWe);
            fr_seen += int'(FrameCtrl);
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL stream: unexpected FIFOWe=%0b FrameCtrl=%0b RGBData=%02h, expected none",
                         FIFOWe, FrameCtrl, RGBData);
            end else begin
                cmp_e = exp_q.pop_front();
                if (FIFOWe !== cmp_e.we || FrameCtrl !== cmp_e.frame ||
                    (cmp_e.we && RGBData !== cmp_e.data)) begin
                    miscompares++;
                    $display("FAIL stream: got we=%0b fr=%0b d=%02h, expected we=%0b fr=%0b d=%02h",
                             FIFOWe, FrameCtrl, RGBData, cmp_e.we, cmp_e.frame, cmp_e.data);
                end
            end
        end
    end

    task automatic check_status();
        int exp_cnt;
`ifdef FIFO_OVF_CNT_EN
        exp_cnt = m_ovfcnt;
`else
        exp_cnt = 0;
`endif
        check("LCD_BL", 32'(LCD_BL), 32'(m_bl));
        check("Busy", 32'(Busy), 32'(m_mode == 3));
        check("Overflow", 32'(Overflow), 32'(m_ovf));
        check("OvfCnt", 32'(OvfCnt), 32'(exp_cnt));
        check("stream_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic send(input bit rs, input logic [7:0] d, input bit full);
        @(posedge CLK); #1;
        i8080_CS = 1'b0; i8080_RS = rs; i8080_D = d; FIFO_Full = full; i8080_WR = 1'b0;
        repeat (2) @(posedge CLK);
        #1 i8080_WR = 1'b1;
        model_byte(rs, d, full);
        repeat (S + 3) @(posedge CLK);
        #1 i8080_CS = 1'b1;
        check_status();
    endtask

    task automatic cmd(input logic [7:0] c);
        send(1'b0, c, 1'b0);
    endtask

    task automatic win(input logic [7:0] c, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] x, input logic [7:0] y);
        cmd(c);
        send(1'b1, a, 1'b0); send(1'b1, b, 1'b0); send(1'b1, x, 1'b0); send(1'b1, y, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_FIFOWe"}, 32'(FIFOWe), 32'd0);
        check({tag, "_RGBData"}, 32'(RGBData), 32'd0);
        check({tag, "_FrameCtrl"}, 32'(FrameCtrl), 32'd0);
        check({tag, "_LCD_BL"}, 32'(LCD_BL), 32'd0);
        check({tag, "_Busy"}, 32'(Busy), 32'd0);
        check({tag, "_Overflow"}, 32'(Overflow), 32'd0);
        check({tag, "_OvfCnt"}, 32'(OvfCnt), 32'd0);
    endtask

    int we0, fr0, n, lo, sel;
    logic [7:0] c8;

    initial begin
        nRST = 1'b0; i8080_CS = 1'b1; i8080_RS = 1'b1; i8080_WR = 1'b1;
        i8080_D = 8'h00; FIFO_Full = 1'b0;
        m_reset();
        repeat (3) @(posedge CLK);
        #1 check_reset_outputs("reset");
        nRST = 1'b1;
        repeat (2) @(posedge CLK);

        // DISPON latency: backlight rises exactly S+1 clocks after the WR pin edge
        @(posedge CLK); #1;
        i8080_CS = 1'b0; i8080_RS = 1'b0; i8080_D = 8'h29; i8080_WR = 1'b0;
        repeat (2) @(posedge CLK);
        #1 i8080_WR = 1'b1;
        model_byte(1'b0, 8'h29, 1'b0);
        repeat (S) @(posedge CLK);
        #1 check("bl_before_latency", 32'(LCD_BL), 32'd0);
        @(posedge CLK);
        #1 check("bl_at_latency", 32'(LCD_BL), 32'd1);
        repeat (2) @(posedge CLK);
        #1 i8080_CS = 1'b1;

        // Small window, 2 cols x 2 rows
        win(8'h2A, 8'h00, 8'h02, 8'h00, 8'h03);
        win(8'h2B, 8'h00, 8'h00, 8'h00, 8'h01);
        cmd(8'h2C);
        we0 = we_seen; fr0 = fr_seen;
        for (int i = 0; i < 8; i++) send(1'b1, 8'(8'h10 + i), 1'b0);
        check("t2_fifowe_count", 32'(we_seen - we0), 32'd8);
        check("t2_frame_count", 32'(fr_seen - fr0), 32'd1);
        check("t2_busy", 32'(Busy), 32'd0);
        send(1'b1, 8'h18, 1'b0);
        check("t2_ninth_byte", 32'(we_seen - we0), 32'd8);

        // Full-screen RAMWR aborted by an unknown command
        win(8'h2A, 8'h00, 8'h00, 8'h03, 8'h1F);
        win(8'h2B, 8'h00, 8'h00, 8'h01, 8'hDF);
        cmd(8'h2C);
        we0 = we_seen; fr0 = fr_seen;
        for (int i = 0; i < 1000; i++) send(1'b1, 8'($urandom), 1'b0);
        cmd(8'h00);
        check("t3_fifowe_count", 32'(we_seen - we0), 32'd1000);
        check("t3_no_frame", 32'(fr_seen - fr0), 32'd0);
        check("t3_busy", 32'(Busy), 32'd0);

        // FIFO full on 3 of 8 bytes, including the last
        win(8'h2A, 8'h00, 8'h00, 8'h00, 8'h01);
        win(8'h2B, 8'h00, 8'h00, 8'h00, 8'h01);
        cmd(8'h2C);
        we0 = we_seen; fr0 = fr_seen;
        for (int i = 0; i < 8; i++) send(1'b1, 8'(8'hA0 + i), (i == 2 || i == 4 || i == 7));
        check("t4_fifowe_count", 32'(we_seen - we0), 32'd5);
        check("t4_frame_count", 32'(fr_seen - fr0), 32'd1);
        check("t4_overflow", 32'(Overflow), 32'd1);
`ifdef FIFO_OVF_CNT_EN
        check("t4_ovfcnt", 32'(OvfCnt), 32'd3);
`else
        check("t4_ovfcnt", 32'(OvfCnt), 32'd0);
`endif

        // Partial CASET discarded; then clamped end column
        cmd(8'h2A); send(1'b1, 8'h00, 1'b0); send(1'b1, 8'h05, 1'b0);
        win(8'h2B, 8'h00, 8'h00, 8'h00, 8'h00);
        cmd(8'h2C);
        fr0 = fr_seen;
        for (int i = 0; i < 4; i++) send(1'b1, 8'(i), 1'b0);
        check("t5_partial_discard", 32'(fr_seen - fr0), 32'd1);
        win(8'h2A, 8'h00, 8'h09, 8'h00, 8'h04);
        win(8'h2B, 8'h00, 8'h00, 8'h00, 8'h00);
        cmd(8'h2C);
        fr0 = fr_seen;
        send(1'b1, 8'h55, 1'b0); send(1'b1, 8'h66, 1'b0);
        check("t5_clamped_frame", 32'(fr_seen - fr0), 32'd1);

        // Reset mid-RAMWR, then SWRESET restores the full-width window
        win(8'h2A, 8'h00, 8'h00, 8'h00, 8'h01);
        win(8'h2B, 8'h00, 8'h00, 8'h00, 8'h01);
        cmd(8'h2C);
        for (int i = 0; i < 3; i++) send(1'b1, 8'(8'h30 + i), 1'b0);
        @(posedge CLK); #1 nRST = 1'b0;
        m_reset(); exp_q.delete();
        repeat (2) @(posedge CLK);
        #1 check_reset_outputs("midreset");
        nRST = 1'b1;
        we0 = we_seen;
        for (int i = 0; i < 3; i++) send(1'b1, 8'(8'h40 + i), 1'b0);
        check("t6_idle_after_reset", 32'(we_seen - we0), 32'd0);
        win(8'h2A, 8'h00, 8'h00, 8'h00, 8'h01);
        cmd(8'h01);
        win(8'h2B, 8'h00, 8'h00, 8'h00, 8'h00);
        cmd(8'h2C);
        fr0 = fr_seen;
        for (int i = 0; i < 2 * H_RES - 1; i++) send(1'b1, 8'($urandom), 1'b0);
        check("t6_no_early_frame", 32'(fr_seen - fr0), 32'd0);
        send(1'b1, 8'hEE, 1'b0);
        check("t6_swreset_ec", 32'(fr_seen - fr0), 32'd1);

        // Randomized command/data mix against the model
        for (int it = 0; it < 40; it++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 5) begin
                lo = int'($urandom_range(0, 5));
                win(8'h2A, 8'({$urandom_range(0, 63), 2'b00}), 8'(lo),
                    8'({$urandom_range(0, 63), 2'b00}), 8'(lo + int'($urandom_range(0, 5)) - 2));
                lo = int'($urandom_range(0, 4));
                win(8'h2B, 8'h00, 8'(lo), 8'h00, 8'(lo + int'($urandom_range(0, 4)) - 1));
                cmd(8'h2C);
                n = int'($urandom_range(0, 40));
                for (int i = 0; i < n; i++)
                    send(1'b1, 8'($urandom), ($urandom_range(0, 4) == 0));
            end else if (sel == 5) begin
                cmd(($urandom_range(0, 1) == 1) ? 8'h29 : 8'h28);
            end else if (sel == 6) begin
                cmd(8'h2B);
                n = int'($urandom_range(0, 3));
                for (int i = 0; i < n; i++) send(1'b1, 8'($urandom), 1'b0);
            end else if (sel == 7) begin
                c8 = 8'($urandom_range(0, 3));
                cmd((c8 == 8'd0) ? 8'h00 : (c8 == 8'd1) ? 8'h11 : (c8 == 8'd2) ? 8'h36 : 8'h3A);
                send(1'b1, 8'($urandom), 1'b0);
            end else if (sel == 8) begin
                cmd(8'h01);
            end else begin
                cmd(8'h2C);
                n = int'($urandom_range(0, 10));
                for (int i = 0; i < n; i++)
                    send(1'b1, 8'($urandom), ($urandom_range(0, 3) == 0));
            end
        end

        repeat (5) @(posedge CLK);
        #1 check("final_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
